mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit for the multicycle MIPS datapath.
- Sits directly downstream of the control unit and is driven by its MultControl/DivControl strobes. Operands come from the A/B registers.
- Produces HI/LO for MFHI/MFLO and a done pulse so the control FSM can leave its wait state.
- One bit per cycle; fixed latency.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mult_div_unit_if.sv | 36 +++
 rtl/mult_div_unit_step.sv | 55 +++++
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide FSM states, unit sizing and the funct codes
// the control unit decodes into MultControl/DivControl.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/operand/result bundle between the control unit and mult_div_unit.
// MULT_DIV_UNSIGNED_EN adds the is_unsigned select sampled with the start strobe.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             MultControl;
  logic             DivControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
`ifdef MULT_DIV_UNSIGNED_EN
  logic             is_unsigned;

  modport master (
    output MultControl, DivControl, a, b, is_unsigned,
    input  hi, lo, busy, done, div_zero
  );
  modport slave (
    input  MultControl, DivControl, a, b, is_unsigned,
    output hi, lo, busy, done, div_zero
  );
`else
  modport master (
    output MultControl, DivControl, a, b,
    input  hi, lo, busy, done, div_zero
  );
  modport slave (
    input  MultControl, DivControl, a, b,
    output hi, lo, busy, done, div_zero
  );
`endif
endinterface

// File: rtl/mult_div_unit_step.sv
// One iteration of the multiply/divide datapath: Booth (or plain shift-add) step or one
// restoring-divide quotient bit. Accumulator layout is {upper, lower, booth_prev}.
module md_datapath_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   m,
  input  logic [2*WIDTH:0]   acc,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic             q_prev;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   up_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    upper  = acc[2*WIDTH:WIDTH+1];
    lower  = acc[WIDTH:1];
    q_prev = acc[0];

    // One guard bit keeps upper +/- m exact, including for the most negative multiplicand
    m_ext  = {is_signed & m[WIDTH-1], m};
    up_ext = {is_signed & upper[WIDTH-1], upper};
    sum    = up_ext;
    if (is_signed) begin
      if (lower[0] && !q_prev) begin
        sum = up_ext - m_ext;
      end else if (!lower[0] && q_prev) begin
        sum = up_ext + m_ext;
      end
    end else if (lower[0]) begin
      sum = up_ext + m_ext;
    end

    rem_sh = {upper, lower[WIDTH-1]};
    diff   = rem_sh - {1'b0, m};

    if (is_div) begin
      if (diff[WIDTH]) begin
        acc_next = {rem_sh[WIDTH-1:0], lower[WIDTH-2:0], 1'b0, 1'b0};
      end else begin
        acc_next = {diff[WIDTH-1:0], lower[WIDTH-2:0], 1'b1, 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing HI/LO for MFHI/MFLO, one bit per cycle.
// MULT_DIV_UNSIGNED_EN enables MULTU/DIVU via bus.is_unsigned; otherwise all ops are signed.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] m_q, m_d;
  logic             signed_q, signed_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             uns_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c;
  logic [WIDTH-1:0] quo_c, rem_c;

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns_c = bus.is_unsigned;
`else
  assign uns_c = 1'b0;
`endif

  assign a_abs_c = (!uns_c && bus.a[WIDTH-1]) ? WIDTH'(0) - bus.a : bus.a;
  assign b_abs_c = (!uns_c && bus.b[WIDTH-1]) ? WIDTH'(0) - bus.b : bus.b;

  md_datapath_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (state_q == DIV),
    .is_signed (signed_q),
    .m         (m_q),
    .acc       (acc_q),
    .acc_next  (acc_step)
  );

  assign quo_c = acc_step[WIDTH:1];
  assign rem_c = acc_step[2*WIDTH:WIDTH+1];

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    signed_d  = signed_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.MultControl) begin
          state_d  = MULT;
          cnt_d    = CNT_W'(WIDTH - 1);
          acc_d    = {WIDTH'(0), bus.b, 1'b0};
          m_d      = bus.a;
          signed_d = !uns_c;
        end else if (bus.DivControl) begin
          signed_d  = !uns_c;
          neg_quo_d = !uns_c && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = !uns_c && bus.a[WIDTH-1];
          if (bus.b == WIDTH'(0)) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV;
            cnt_d   = CNT_W'(WIDTH - 1);
            acc_d   = {WIDTH'(0), a_abs_c, 1'b0};
            m_d     = b_abs_c;
          end
        end
      end
      MULT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(0)) begin
          state_d = DONE;
          hi_d    = rem_c;
          lo_d    = quo_c;
        end
      end
      DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(0)) begin
          state_d = DONE;
          hi_d    = neg_rem_q ? WIDTH'(0) - rem_c : rem_c;
          lo_d    = neg_quo_q ? WIDTH'(0) - quo_c : quo_c;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      signed_q  <= signed_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO/flag/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           start;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sbq[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compare every done pulse against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
          end else begin
            e = sbq.pop_front();
            chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
            chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
            chk({e.name, "_dz"}, 64'(bus.div_zero), 64'(e.dz));
            chk({e.name, "_lat"}, 64'(cyc - e.start), 64'(e.lat));
            chk({e.name, "_busy"}, 64'(busy_cnt), 64'(e.lat));
          end
        end
        if (!bus.busy) busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1 after %0d cycles expected idle", n);
    end
  endtask

  task automatic issue(input logic mc, input logic dc, input logic uns,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edz, input int lat, input string name);
    exp_t e;
    wait_idle();
    bus.MultControl = mc;
    bus.DivControl  = dc;
`ifdef MULT_DIV_UNSIGNED_EN
    bus.is_unsigned = uns;
`else
    if (uns) $display("note: unsigned op requested in signed-only build");
`endif
    bus.a = a;
    bus.b = b;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = lat; e.start = cyc; e.name = name;
    sbq.push_back(e);
    @(negedge clk);
    bus.MultControl = 1'b0;
    bus.DivControl  = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    bus.MultControl = 1'b0;
    bus.DivControl  = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef MULT_DIV_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(1, 0, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, "mul_7_m3");

    // Abort mid-multiply: no done, registers cleared immediately
    issue(1, 0, 0, 32'd1000, 32'd1000, 32'd0, 32'd0, 0, 33, "mul_abort");
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    issue(0, 1, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, "div_m7_2");
    issue(0, 1, 0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, 33, "div_7_m2");
    issue(0, 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 33, "div_100_7");
    issue(0, 1, 0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 0, 33, "div_m100_m7");
    issue(0, 1, 0, 32'd68, 32'd7, 32'd5, 32'd9, 0, 33, "div_68_7");
    issue(0, 1, 0, 32'h1234, 32'd0, 32'd5, 32'd9, 1, 1, "div_zero");
    issue(0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 33, "div_ovf");
    issue(1, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 0, 33, "mul_min_min");
    issue(1, 0, 0, 32'h12345678, 32'h10, 32'd1, 32'h23456780, 0, 33, "mul_shift");
    issue(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 0, 33, "mul_m1_m1");

    // Both strobes: multiply wins; strobes while busy or in DONE are ignored
    issue(1, 1, 0, 32'd6, 32'd4, 32'd0, 32'd24, 0, 33, "mul_both");
    repeat (5) @(negedge clk);
    bus.MultControl = 1'b1;
    bus.a = 32'd100;
    bus.b = 32'd100;
    @(negedge clk);
    bus.MultControl = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done after %0d cycles expected done", n);
    end
    bus.MultControl = 1'b1;
    bus.DivControl  = 1'b1;
    @(negedge clk);
    bus.MultControl = 1'b0;
    bus.DivControl  = 1'b0;
    chk("strobe_in_done_busy", 64'(bus.busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("strobe_in_done_lo", 64'(bus.lo), 64'd24);

`ifdef MULT_DIV_UNSIGNED_EN
    issue(1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 33, "multu_max");
    issue(0, 1, 1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'h7FFFFFFF, 0, 33, "divu_max");
`endif

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
